// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive path.
// Holds the frame FSM state encoding and the slot-index width rule.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // A two-slot frame still needs one bit of slot index.
  function automatic int slot_bits(input int channels);
    return ($clog2(channels) > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Shared-line input and published-frame output bundle of the TDM demux.
// The master drives the line and consumes frames; the slave is the demux.
interface tdm_demux_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2
);
  localparam int SW = tdm_pkg::slot_bits(CHANNELS);

  logic                      en;
  logic                      frame_sync;
  logic [WIDTH-1:0]          din;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic                      frame_valid;
  logic                      locked;
  logic [SW-1:0]             slot;
  logic                      sync_err;

  modport master (
    output en, frame_sync, din,
    input  dout, frame_valid, locked, slot, sync_err
  );

  modport slave (
    input  en, frame_sync, din,
    output dout, frame_valid, locked, slot, sync_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Modulo-CHANNELS slot counter with clear-to-0, load-to-1 and increment.
// Latency: one cycle; no backpressure, controls are single-cycle strobes.
module tdm_slot_counter #(
  parameter int CHANNELS = 2,
  parameter int SW       = tdm_pkg::slot_bits(CHANNELS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          load,
  input  logic          inc,
  output logic [SW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == SW'(CHANNELS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= SW'(1);
    end else if (inc) begin
      cnt <= last ? '0 : cnt + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Recovers per-channel words from a shared line with frame marker; publishes whole frames.
// Latency: one cycle from last slot to dout/frame_valid; no backpressure, en gates sampling.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  tdm_demux_if.slave bus
);

  localparam int SW = slot_bits(CHANNELS);

  state_t                         state;
  logic [(CHANNELS-1)*WIDTH-1:0]  shadow;
  logic [CHANNELS*WIDTH-1:0]      dout_q;
  logic                           frame_valid_q;
  logic                           sync_err_q;
  logic [SW-1:0]                  slot;
  logic                           last;
  logic                           at_zero;
  logic                           cnt_clr;
  logic                           cnt_load;
  logic                           cnt_inc;

  assign at_zero = (slot == '0);

  always_comb begin
    cnt_load = bus.en && bus.frame_sync;
    cnt_inc  = bus.en && !bus.frame_sync && (state == LOCKED) && !at_zero;
    cnt_clr  = bus.en && !bus.frame_sync && (state == LOCKED) && at_zero;
  end

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SW       (SW)
  ) u_slot_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .cnt     (slot),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HUNT;
      shadow        <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (bus.en) begin
        case (state)
          HUNT: begin
            if (bus.frame_sync) begin
              shadow[WIDTH-1:0] <= bus.din;
              state             <= LOCKED;
            end
          end
          LOCKED: begin
            if (bus.frame_sync) begin
              // A sync anywhere but slot 0 abandons the partial frame.
              shadow[WIDTH-1:0] <= bus.din;
              sync_err_q        <= !at_zero;
            end else if (at_zero) begin
              sync_err_q <= 1'b1;
              state      <= HUNT;
            end else if (last) begin
              // The final slot bypasses the shadow and lands directly in dout.
              dout_q        <= {bus.din, shadow};
              frame_valid_q <= 1'b1;
            end else begin
              for (int k = 1; k < CHANNELS - 1; k++) begin
                if (slot == SW'(k)) shadow[k*WIDTH +: WIDTH] <= bus.din;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state == LOCKED);
  assign bus.slot        = slot;

endmodule

// File: tb/tb_tdm_demux.sv
// Drives two demux instances (2 and 4 channels, 4-bit words) from one shared line
// and compares every cycle against a queue-based frame model.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       fs;
  logic [3:0] din;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  tdm_demux_if #(.WIDTH(4), .CHANNELS(2)) bus0 ();
  tdm_demux_if #(.WIDTH(4), .CHANNELS(4)) bus1 ();

  assign bus0.en = en;
  assign bus0.frame_sync = fs;
  assign bus0.din = din;
  assign bus1.en = en;
  assign bus1.frame_sync = fs;
  assign bus1.din = din;

  tdm_demux #(.WIDTH(4), .CHANNELS(2)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  tdm_demux #(.WIDTH(4), .CHANNELS(4)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  // Model: words collected since the last accepted sync; a full queue is a frame.
  int          chans [2] = '{2, 4};
  logic [3:0]  mq [2][$];
  bit          mlock [2];
  logic [15:0] mdout [2];
  bit          mfv [2];
  bit          mse [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      mlock[i] = 1'b0;
      mdout[i] = '0;
      mfv[i]   = 1'b0;
      mse[i]   = 1'b0;
    end
  endtask

  task automatic model_step(input bit e, input bit s, input logic [3:0] d);
    for (int i = 0; i < 2; i++) begin
      mfv[i] = 1'b0;
      mse[i] = 1'b0;
      if (e) begin
        if (s) begin
          if (mlock[i] && mq[i].size() > 0) mse[i] = 1'b1;
          mq[i].delete();
          mq[i].push_back(d);
          mlock[i] = 1'b1;
        end else if (mlock[i]) begin
          if (mq[i].size() == 0) begin
            mse[i]   = 1'b1;
            mlock[i] = 1'b0;
          end else begin
            mq[i].push_back(d);
            if (mq[i].size() == chans[i]) begin
              mdout[i] = '0;
              for (int k = 0; k < chans[i]; k++) mdout[i][k*4 +: 4] = mq[i][k];
              mq[i].delete();
              mfv[i] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dout0",  16'(bus0.dout),        mdout[0]);
    chk("fv0",    16'(bus0.frame_valid), 16'(mfv[0]));
    chk("serr0",  16'(bus0.sync_err),    16'(mse[0]));
    chk("lock0",  16'(bus0.locked),      16'(mlock[0]));
    chk("slot0",  16'(bus0.slot),        16'(mq[0].size()));
    chk("excl0",  16'(bus0.frame_valid & bus0.sync_err), 16'h0);
    chk("dout1",  16'(bus1.dout),        mdout[1]);
    chk("fv1",    16'(bus1.frame_valid), 16'(mfv[1]));
    chk("serr1",  16'(bus1.sync_err),    16'(mse[1]));
    chk("lock1",  16'(bus1.locked),      16'(mlock[1]));
    chk("slot1",  16'(bus1.slot),        16'(mq[1].size()));
    chk("excl1",  16'(bus1.frame_valid & bus1.sync_err), 16'h0);
  endtask

  task automatic cyc(input bit e, input bit s, input logic [3:0] d);
    en  = e;
    fs  = s;
    din = d;
    @(posedge clk);
    model_step(e, s, d);
    #1;
    check_all();
  endtask

  // Reset lands mid-cycle so the asynchronous clear is observed before any edge.
  task automatic apply_reset();
    #2;
    reset_n = 1'b0;
    en      = 1'b0;
    #1;
    chk("rst_dout0", 16'(bus0.dout), 16'h0);
    chk("rst_dout1", 16'(bus1.dout), 16'h0);
    chk("rst_lock",  16'({bus0.locked, bus1.locked}), 16'h0);
    chk("rst_slot",  16'({bus0.slot, bus1.slot}), 16'h0);
    chk("rst_pulse", 16'({bus0.frame_valid, bus0.sync_err, bus1.frame_valid, bus1.sync_err}), 16'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    int pulses;
    reset_n = 1'b0;
    en      = 1'b0;
    fs      = 1'b0;
    din     = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Traffic, then reset mid-stream and idle with en low.
    cyc(1'b1, 1'b1, 4'h3);
    cyc(1'b1, 1'b0, 4'h6);
    cyc(1'b1, 1'b0, 4'h9);
    apply_reset();
    repeat (2) cyc(1'b0, 1'b1, 4'hF);

    // Lock and frame.
    cyc(1'b1, 1'b1, 4'hA);
    cyc(1'b1, 1'b0, 4'h5);
    chk("lf_dout", 16'(bus0.dout), 16'h5A);
    chk("lf_fv",   16'(bus0.frame_valid), 16'h1);
    chk("lf_slot", 16'(bus0.slot), 16'h0);
    cyc(1'b0, 1'b0, 4'h0);
    chk("lf_fv_off", 16'(bus0.frame_valid), 16'h0);

    // Hunt discard.
    apply_reset();
    cyc(1'b1, 1'b0, 4'h1);
    cyc(1'b1, 1'b0, 4'h2);
    cyc(1'b1, 1'b0, 4'h3);
    chk("hd_noerr", 16'(bus0.sync_err), 16'h0);
    cyc(1'b1, 1'b1, 4'h4);
    cyc(1'b1, 1'b0, 4'h7);
    chk("hd_dout", 16'(bus0.dout), 16'h74);

    // Gapped en with sync toggling while en is low.
    apply_reset();
    cyc(1'b1, 1'b1, 4'hA);
    cyc(1'b0, 1'b0, 4'h1);
    cyc(1'b0, 1'b1, 4'h2);
    cyc(1'b0, 1'b0, 4'h3);
    chk("gap_fv_wait", 16'(bus0.frame_valid), 16'h0);
    cyc(1'b1, 1'b0, 4'h5);
    chk("gap_dout", 16'(bus0.dout), 16'h5A);
    chk("gap_fv",   16'(bus0.frame_valid), 16'h1);

    // Missing sync on the 2-channel instance.
    cyc(1'b1, 1'b1, 4'h3);
    cyc(1'b1, 1'b0, 4'hC);
    chk("ms_good", 16'(bus0.dout), 16'hC3);
    cyc(1'b1, 1'b0, 4'hE);
    chk("ms_serr", 16'(bus0.sync_err), 16'h1);
    chk("ms_lock", 16'(bus0.locked), 16'h0);
    chk("ms_hold", 16'(bus0.dout), 16'hC3);
    cyc(1'b1, 1'b1, 4'h1);
    chk("ms_relock", 16'(bus0.locked), 16'h1);
    cyc(1'b1, 1'b0, 4'h2);
    chk("ms_dout", 16'(bus0.dout), 16'h21);

    // Early sync on the 4-channel instance.
    apply_reset();
    cyc(1'b1, 1'b1, 4'h1);
    cyc(1'b1, 1'b0, 4'h2);
    cyc(1'b1, 1'b1, 4'h9);
    chk("es_serr", 16'(bus1.sync_err), 16'h1);
    chk("es_keep", 16'(bus1.dout), 16'h0);
    cyc(1'b1, 1'b0, 4'h8);
    cyc(1'b1, 1'b0, 4'h7);
    chk("es_nofv", 16'(bus1.frame_valid), 16'h0);
    cyc(1'b1, 1'b0, 4'h6);
    chk("es_dout", 16'(bus1.dout), 16'h6789);
    chk("es_fv",   16'(bus1.frame_valid), 16'h1);

    // Back-to-back frames: one pulse per CHANNELS cycles.
    apply_reset();
    pulses = 0;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(1'b1, k == 0, 4'($urandom));
        pulses += int'(bus1.frame_valid);
      end
    end
    chk("b2b_pulses", 16'(pulses), 16'd5);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) apply_reset();
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
